lfsr16_checker: RTL and testbench
=================================

# lfsr16_checker

Receive-side companion to the 16-state, 5-bit modified LFSR generator. Samples a stream of 5-bit LFSR words, recovers each word's sequence index (0..15), acquires and holds lock to the sequence, and flags and counts deviations. It sits at the far end of any link or memory path carrying the generator output, as a built-in self-test checker.

## Interface
- LOCK_CNT, 3: consecutive in-sequence samples needed to declare lock (1..15).
- UNLOCK_CNT, 2: consecutive mismatches while locked that drop lock (1..15).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- vld  in  1  din carries a sample this cycle.
- din  in  5  sampled LFSR word.
- clr  in  1  synchronous clear of err_cnt.
- lock  out  1  checker locked to sequence.
- idx  out  4  sequence index of last valid-code sample.
- idx_vld  out  1  one-cycle pulse: idx updated.
- err  out  1  one-cycle pulse: mismatch while locked.
- err_cnt  out  8  saturating mismatch count.

## Operation
- Sequence, index 0..15: 10000, 00001, 00011, 00111, 01111, 11110, 11101, 11010, 10101, 01011, 10110, 01100, 11001, 10010, 00100, 01000, then wraps to 10000.
- Successor rule: next(x) = {x[3:0], x[3]^x[0]^~|x[2:0]}.
- Valid code: any of the 16 words above. The other 16 are invalid: 00000, 00010, 00101, 00110, 01001, 01010, 01101, 01110, 10001, 10011, 10100, 10111, 11000, 11011, 11100, 11111.
- Index decode is per sample and independent of state.
  - Valid din with vld: idx <= index(din), idx_vld pulses.
  - Invalid din: idx holds, no pulse.
- Internal state: exp[4:0] (expected next word), good counter, bad counter, and FSM {HUNT, SYNC, LOCKED}.
- Cycles with vld=0 change nothing. State, counters and exp all hold, with no timeout.
- HUNT:
  - Valid din: exp <= next(din), good <= 1. Go to LOCKED if LOCK_CNT=1, else SYNC.
  - Invalid din: stay in HUNT.
- SYNC:
  - din==exp: good++, exp <= next(din). Go to LOCKED when good reaches LOCK_CNT.
  - din!=exp but valid: restart with good <= 1, exp <= next(din).
  - Invalid din: go to HUNT.
  - No err is raised in HUNT or SYNC.
- LOCKED:
  - din==exp: bad <= 0, exp <= next(exp).
  - din!=exp (invalid codes included): err pulses, err_cnt increments, bad++, exp <= next(exp). This is the flywheel: exp keeps advancing through errors.
  - When bad reaches UNLOCK_CNT: go to HUNT and deassert lock.
- lock = (state==LOCKED).
- err_cnt saturates at 255.
  - clr has priority over a same-cycle increment: result is 0.
  - clr does not affect lock or FSM state.

## Timing
- All outputs registered. A sample accepted at edge N is reflected in idx, idx_vld, err, err_cnt and lock after edge N.
- lock asserts at the edge that accepts the LOCK_CNT-th consecutive matching sample. It deasserts at the edge accepting the UNLOCK_CNT-th consecutive mismatch.
- Throughput: one sample per cycle, with no backpressure.
- Reset values: lock=0, idx=0, idx_vld=0, err=0, err_cnt=0, FSM=HUNT, exp=10000, good=bad=0.
- rst mid-operation (any state): all of the above are restored at the next edge, and vld is ignored that cycle.
- rst dominates clr and vld.

## Test plan
- **Clean acquisition** (defaults): after reset, drive 10000, 00001, 00011, 00111 with vld=1.
  - idx = 0, 1, 2, 3, idx_vld every cycle.
  - lock=1 after the 3rd sample; err stays 0.
  - Continue 40 samples across the wrap 01000 -> 10000: idx goes 15 -> 0, no err.
- **Invalid codes / gaps:** in HUNT drive 00000, 11111, with vld=1 on both.
  - idx_vld=0, lock=0.
  - Insert vld=0 gaps mid-SYNC: state holds, lock still asserts after 3 matches.
- **Single error flywheel:** locked, expecting 11110, drive 11101.
  - err pulse, err_cnt=1, lock stays 1, idx=6.
  - Next drive 11101, the correct continuation: no err.
- **Loss of lock:** locked, two consecutive wrong samples.
  - err twice, err_cnt=2, lock=0 after the 2nd.
  - Then 3 correct samples: relock.
- **Saturation/clear:** force 300 mismatches with UNLOCK_CNT=15 and periodic correct samples.
  - err_cnt stops at 255.
  - clr together with an err: err_cnt=0.
- **Reset mid-lock:** assert rst while locked with err_cnt=5.
  - Next cycle: lock=0, err_cnt=0, idx=0, FSM in HUNT.
  - Reacquires from any phase of the sequence.

Source files
------------

// File: rtl/lfsr16_checker.sv
// lfsr16_checker: receive-side checker for the 16-state, 5-bit modified LFSR.
// It recovers each sample's sequence index, acquires and holds lock to the
// sequence, and flags and counts deviations while locked. While locked, the
// expected word keeps advancing through errors (flywheel).
module lfsr16_checker #(
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld,
  input  logic [4:0] din,
  input  logic       clr,
  output logic       lock,
  output logic [3:0] idx,
  output logic       idx_vld,
  output logic       err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_t;

  // First word of the sequence; exp restarts here after reset.
  localparam logic [4:0] SEED_WORD = 5'b10000;

  // Both targets fit in 4 bits because the allowed range is 1..15.
  localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

  // Successor of a sequence word. The NOR term lets the all-zero-low case
  // escape the lock-up state, which gives 16 states instead of 15.
  function automatic logic [4:0] lfsr_next(input logic [4:0] x);
    return {x[3:0], x[3] ^ x[0] ^ ~|x[2:0]};
  endfunction

  // Map a word to {valid, index}. Any word outside the sequence returns all zeros.
  function automatic logic [4:0] decode(input logic [4:0] w);
    logic [4:0] r;
    case (w)
      5'b10000: r = {1'b1, 4'd0};
      5'b00001: r = {1'b1, 4'd1};
      5'b00011: r = {1'b1, 4'd2};
      5'b00111: r = {1'b1, 4'd3};
      5'b01111: r = {1'b1, 4'd4};
      5'b11110: r = {1'b1, 4'd5};
      5'b11101: r = {1'b1, 4'd6};
      5'b11010: r = {1'b1, 4'd7};
      5'b10101: r = {1'b1, 4'd8};
      5'b01011: r = {1'b1, 4'd9};
      5'b10110: r = {1'b1, 4'd10};
      5'b01100: r = {1'b1, 4'd11};
      5'b11001: r = {1'b1, 4'd12};
      5'b10010: r = {1'b1, 4'd13};
      5'b00100: r = {1'b1, 4'd14};
      5'b01000: r = {1'b1, 4'd15};
      default:  r = 5'b0_0000;
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [4:0] exp_q, exp_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic [3:0] idx_d;
  logic       idx_vld_d;
  logic       err_d;
  logic [7:0] err_cnt_d;

  logic [4:0] dec;
  logic       din_valid;
  logic [3:0] din_index;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;
  logic       din_match;

  // Per-sample decode does not depend on the checker state.
  assign dec       = decode(din);
  assign din_valid = dec[4];
  assign din_index = dec[3:0];
  assign din_match = (din == exp_q);
  assign good_inc  = good_q + 4'd1;
  assign bad_inc   = bad_q + 4'd1;

  // Next state of the acquisition FSM, the expected word, the match and
  // mismatch run counters, and the per-sample output pulses.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    good_d    = good_q;
    bad_d     = bad_q;
    idx_d     = idx;
    idx_vld_d = 1'b0;
    err_d     = 1'b0;

    if (vld) begin
      if (din_valid) begin
        idx_d     = din_index;
        idx_vld_d = 1'b1;
      end

      case (state_q)
        HUNT: begin
          if (din_valid) begin
            exp_d   = lfsr_next(din);
            good_d  = 4'd1;
            bad_d   = 4'd0;
            state_d = (LOCK_TGT == 4'd1) ? LOCKED : SYNC;
          end
        end

        SYNC: begin
          if (!din_valid) begin
            good_d  = 4'd0;
            state_d = HUNT;
          end else if (din_match) begin
            good_d = good_inc;
            exp_d  = lfsr_next(din);
            if (good_inc == LOCK_TGT) begin
              bad_d   = 4'd0;
              state_d = LOCKED;
            end
          end else begin
            // A valid but out-of-order word becomes the new first candidate.
            good_d = 4'd1;
            exp_d  = lfsr_next(din);
          end
        end

        LOCKED: begin
          // The flywheel advances from exp, not from din, so an isolated
          // corrupted sample does not knock the checker off phase.
          exp_d = lfsr_next(exp_q);
          if (din_match) begin
            bad_d = 4'd0;
          end else begin
            err_d = 1'b1;
            bad_d = bad_inc;
            if (bad_inc == UNLOCK_TGT) begin
              state_d = HUNT;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // Saturating error counter. A clear wins over an increment in the same cycle.
  always_comb begin
    err_cnt_d = err_cnt;
    if (clr) begin
      err_cnt_d = 8'd0;
    end else if (err_d && (err_cnt != 8'hFF)) begin
      err_cnt_d = err_cnt + 8'd1;
    end
  end

  // State and output registers. A synchronous reset overrides vld and clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q   <= SEED_WORD;
      good_q  <= 4'd0;
      bad_q   <= 4'd0;
      idx     <= 4'd0;
      idx_vld <= 1'b0;
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      idx     <= idx_d;
      idx_vld <= idx_vld_d;
      err     <= err_d;
      err_cnt <= err_cnt_d;
    end
  end

  assign lock = (state_q == LOCKED);

endmodule

// File: tb/tb_lfsr16_checker.sv
// tb_lfsr16_checker: drives two checker instances from the same inputs: one
// with the default thresholds and one with UNLOCK_CNT=15. Both are compared
// against an index-arithmetic reference model.
module tb_lfsr16_checker;

  logic       clk = 1'b0;
  logic       rst, vld, clr;
  logic [4:0] din;

  logic       lock_a, idx_vld_a, err_a;
  logic [3:0] idx_a;
  logic [7:0] err_cnt_a;
  logic       lock_b, idx_vld_b, err_b;
  logic [3:0] idx_b;
  logic [7:0] err_cnt_b;

  logic [14:0] obs_a, obs_b;

  lfsr16_checker #(.LOCK_CNT(3), .UNLOCK_CNT(2)) dut (
    .clk(clk), .rst(rst), .vld(vld), .din(din), .clr(clr),
    .lock(lock_a), .idx(idx_a), .idx_vld(idx_vld_a), .err(err_a), .err_cnt(err_cnt_a)
  );

  lfsr16_checker #(.LOCK_CNT(3), .UNLOCK_CNT(15)) dut_sat (
    .clk(clk), .rst(rst), .vld(vld), .din(din), .clr(clr),
    .lock(lock_b), .idx(idx_b), .idx_vld(idx_vld_b), .err(err_b), .err_cnt(err_cnt_b)
  );

  assign obs_a = {lock_a, idx_a, idx_vld_a, err_a, err_cnt_a};
  assign obs_b = {lock_b, idx_b, idx_vld_b, err_b, err_cnt_b};

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4:0] seq [16] = '{5'b10000, 5'b00001, 5'b00011, 5'b00111,
                           5'b01111, 5'b11110, 5'b11101, 5'b11010,
                           5'b10101, 5'b01011, 5'b10110, 5'b01100,
                           5'b11001, 5'b10010, 5'b00100, 5'b01000};
  logic [4:0] bad_codes [16] = '{5'b00000, 5'b00010, 5'b00101, 5'b00110,
                                 5'b01001, 5'b01010, 5'b01101, 5'b01110,
                                 5'b10001, 5'b10011, 5'b10100, 5'b10111,
                                 5'b11000, 5'b11011, 5'b11100, 5'b11111};

  localparam int M_HUNT = 0;
  localparam int M_SYNC = 1;
  localparam int M_LOCK = 2;

  int lock_need   [2] = '{3, 3};
  int unlock_need [2] = '{2, 15};
  int m_mode [2];
  int m_exp  [2];
  int m_good [2];
  int m_bad  [2];
  int m_cnt  [2];
  int m_idx  [2];
  bit m_ivld [2];
  bit m_err  [2];

  function automatic int code_index(input logic [4:0] w);
    for (int i = 0; i < 16; i++) begin
      if (seq[i] == w) return i;
    end
    return -1;
  endfunction

  function automatic logic [14:0] model_pack(input int k);
    return {(m_mode[k] == M_LOCK), 4'(m_idx[k]), m_ivld[k], m_err[k], 8'(m_cnt[k])};
  endfunction

  task automatic model_step(input bit v, input logic [4:0] d, input bit c, input bit r);
    int ci;
    ci = code_index(d);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_mode[k] = M_HUNT; m_exp[k] = 0; m_good[k] = 0; m_bad[k] = 0;
        m_cnt[k] = 0; m_idx[k] = 0; m_ivld[k] = 1'b0; m_err[k] = 1'b0;
      end else begin
        m_ivld[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (v) begin
          if (ci >= 0) begin
            m_idx[k]  = ci;
            m_ivld[k] = 1'b1;
          end
          case (m_mode[k])
            M_HUNT: begin
              if (ci >= 0) begin
                m_good[k] = 1;
                m_bad[k]  = 0;
                m_exp[k]  = (ci + 1) % 16;
                m_mode[k] = (lock_need[k] == 1) ? M_LOCK : M_SYNC;
              end
            end
            M_SYNC: begin
              if (ci < 0) begin
                m_mode[k] = M_HUNT;
              end else if (ci == m_exp[k]) begin
                m_good[k] = m_good[k] + 1;
                m_exp[k]  = (ci + 1) % 16;
                if (m_good[k] == lock_need[k]) begin
                  m_mode[k] = M_LOCK;
                  m_bad[k]  = 0;
                end
              end else begin
                m_good[k] = 1;
                m_exp[k]  = (ci + 1) % 16;
              end
            end
            default: begin
              if (ci == m_exp[k]) begin
                m_bad[k] = 0;
              end else begin
                m_err[k] = 1'b1;
                m_bad[k] = m_bad[k] + 1;
                if (m_bad[k] == unlock_need[k]) m_mode[k] = M_HUNT;
              end
              m_exp[k] = (m_exp[k] + 1) % 16;
            end
          endcase
        end
        if (c) m_cnt[k] = 0;
        else if (m_err[k] && m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] d, input bit c, input bit r);
    vld = v; din = d; clr = c; rst = r;
    model_step(v, d, c, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 5'b00000, 1'b0, 1'b1);
    drive(1'b1, 5'b00001, 1'b1, 1'b1);
    checks++;
    if ({obs_a, obs_b} !== 30'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h want %h", {obs_a, obs_b}, 30'd0);
    end
    checks++;
    if ({obs_a, obs_b} !== {model_pack(0), model_pack(1)}) begin
      errors++;
      $display("[TB] FAIL reset_model: got %h want %h", {obs_a, obs_b}, {model_pack(0), model_pack(1)});
    end
  endtask

  task automatic test_clean_acquisition();
    drive(1'b0, 5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i], 1'b0, 1'b0);
      checks++;
      if ({lock_a, idx_a, idx_vld_a, err_a} !== {(i >= 2), 4'(i), 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL acq_step%0d: got %b want %b", i, {lock_a, idx_a, idx_vld_a, err_a},
                 {(i >= 2), 4'(i), 1'b1, 1'b0});
      end
    end
    for (int i = 4; i < 44; i++) begin
      drive(1'b1, seq[i % 16], 1'b0, 1'b0);
      checks++;
      if (obs_a !== {1'b1, 4'(i % 16), 1'b1, 1'b0, 8'd0}) begin
        errors++;
        $display("[TB] FAIL acq_wrap%0d: got %h want %h", i, obs_a, {1'b1, 4'(i % 16), 1'b1, 1'b0, 8'd0});
      end
      checks++;
      if ({obs_a, obs_b} !== {model_pack(0), model_pack(1)}) begin
        errors++;
        $display("[TB] FAIL acq_model%0d: got %h want %h", i, {obs_a, obs_b}, {model_pack(0), model_pack(1)});
      end
    end
  endtask

  task automatic test_invalid_gaps();
    logic [4:0] words [7];
    bit         vlds  [7];
    bit         locks [7];
    int         idxs  [7];
    words = '{5'b00000, 5'b11111, seq[5], 5'b00000, seq[6], 5'b00000, seq[7]};
    vlds  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    locks = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    idxs  = '{0, 0, 5, 5, 6, 6, 7};
    drive(1'b0, 5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(vlds[i], vlds[i] ? words[i] : 5'($urandom), 1'b0, 1'b0);
      checks++;
      if ({lock_a, idx_a, idx_vld_a} !== {locks[i], 4'(idxs[i]), (vlds[i] && i >= 2)}) begin
        errors++;
        $display("[TB] FAIL gap_step%0d: got %b want %b", i, {lock_a, idx_a, idx_vld_a},
                 {locks[i], 4'(idxs[i]), (vlds[i] && i >= 2)});
      end
      checks++;
      if ({obs_a, obs_b} !== {model_pack(0), model_pack(1)}) begin
        errors++;
        $display("[TB] FAIL gap_model%0d: got %h want %h", i, {obs_a, obs_b}, {model_pack(0), model_pack(1)});
      end
    end
  endtask

  task automatic test_flywheel();
    drive(1'b0, 5'b00000, 1'b0, 1'b1);
    for (int i = 2; i < 5; i++) drive(1'b1, seq[i], 1'b0, 1'b0);
    drive(1'b1, 5'b11101, 1'b0, 1'b0);
    checks++;
    if ({err_a, err_cnt_a, lock_a, idx_a} !== {1'b1, 8'd1, 1'b1, 4'd6}) begin
      errors++;
      $display("[TB] FAIL fly_error: got %h want %h", {err_a, err_cnt_a, lock_a, idx_a}, {1'b1, 8'd1, 1'b1, 4'd6});
    end
    drive(1'b1, 5'b11101, 1'b0, 1'b0);
    checks++;
    if ({err_a, err_cnt_a, lock_a, idx_a} !== {1'b0, 8'd1, 1'b1, 4'd6}) begin
      errors++;
      $display("[TB] FAIL fly_recover: got %h want %h", {err_a, err_cnt_a, lock_a, idx_a}, {1'b0, 8'd1, 1'b1, 4'd6});
    end
    checks++;
    if ({obs_a, obs_b} !== {model_pack(0), model_pack(1)}) begin
      errors++;
      $display("[TB] FAIL fly_model: got %h want %h", {obs_a, obs_b}, {model_pack(0), model_pack(1)});
    end
  endtask

  task automatic test_loss_of_lock();
    drive(1'b0, 5'b00000, 1'b0, 1'b1);
    for (int i = 2; i < 5; i++) drive(1'b1, seq[i], 1'b0, 1'b0);
    for (int n = 1; n <= 2; n++) begin
      drive(1'b1, seq[0], 1'b0, 1'b0);
      checks++;
      if ({err_a, err_cnt_a, lock_a} !== {1'b1, 8'(n), (n == 1)}) begin
        errors++;
        $display("[TB] FAIL loss_miss%0d: got %h want %h", n, {err_a, err_cnt_a, lock_a}, {1'b1, 8'(n), (n == 1)});
      end
    end
    for (int i = 10; i < 13; i++) begin
      drive(1'b1, seq[i], 1'b0, 1'b0);
      checks++;
      if ({lock_a, err_a, err_cnt_a} !== {(i == 12), 1'b0, 8'd2}) begin
        errors++;
        $display("[TB] FAIL relock_step%0d: got %h want %h", i, {lock_a, err_a, err_cnt_a}, {(i == 12), 1'b0, 8'd2});
      end
      checks++;
      if ({obs_a, obs_b} !== {model_pack(0), model_pack(1)}) begin
        errors++;
        $display("[TB] FAIL relock_model%0d: got %h want %h", i, {obs_a, obs_b}, {model_pack(0), model_pack(1)});
      end
    end
  endtask

  task automatic test_saturation();
    int p, nmis, iter;
    drive(1'b0, 5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, seq[i], 1'b0, 1'b0);
    p = 3; nmis = 0; iter = 0;
    while (nmis < 300) begin
      if ((iter % 10) == 9) begin
        drive(1'b1, seq[p % 16], 1'b0, 1'b0);
      end else begin
        drive(1'b1, bad_codes[$urandom_range(15)], 1'b0, 1'b0);
        nmis++;
        checks++;
        if (err_cnt_b !== 8'((nmis > 255) ? 255 : nmis)) begin
          errors++;
          $display("[TB] FAIL sat_count%0d: got %0d want %0d", nmis, err_cnt_b, (nmis > 255) ? 255 : nmis);
        end
      end
      p++; iter++;
      checks++;
      if ({obs_a, obs_b} !== {model_pack(0), model_pack(1)}) begin
        errors++;
        $display("[TB] FAIL sat_model%0d: got %h want %h", iter, {obs_a, obs_b}, {model_pack(0), model_pack(1)});
      end
    end
    checks++;
    if ({lock_b, err_cnt_b} !== {1'b1, 8'd255}) begin
      errors++;
      $display("[TB] FAIL sat_hold: got %h want %h", {lock_b, err_cnt_b}, {1'b1, 8'd255});
    end
    drive(1'b1, 5'b00000, 1'b1, 1'b0);
    checks++;
    if ({err_b, err_cnt_b, err_cnt_a, lock_b} !== {1'b1, 8'd0, 8'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL clr_vs_err: got %h want %h", {err_b, err_cnt_b, err_cnt_a, lock_b}, {1'b1, 8'd0, 8'd0, 1'b1});
    end
  endtask

  task automatic test_reset_mid_lock();
    int p, q;
    drive(1'b0, 5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, seq[i], 1'b0, 1'b0);
    p = 3;
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, bad_codes[$urandom_range(15)], 1'b0, 1'b0);
      p++;
      drive(1'b1, seq[p % 16], 1'b0, 1'b0);
      p++;
    end
    checks++;
    if ({lock_a, err_cnt_a} !== {1'b1, 8'd5}) begin
      errors++;
      $display("[TB] FAIL rst_setup: got %h want %h", {lock_a, err_cnt_a}, {1'b1, 8'd5});
    end
    drive(1'b1, seq[p % 16], 1'b0, 1'b1);
    checks++;
    if ({obs_a, obs_b} !== 30'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_lock: got %h want %h", {obs_a, obs_b}, 30'd0);
    end
    q = $urandom_range(15);
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, seq[(q + j) % 16], 1'b0, 1'b0);
      checks++;
      if ({lock_a, lock_b, idx_a} !== {(j == 2), (j == 2), 4'((q + j) % 16)}) begin
        errors++;
        $display("[TB] FAIL rst_reacq%0d: got %h want %h", j, {lock_a, lock_b, idx_a},
                 {(j == 2), (j == 2), 4'((q + j) % 16)});
      end
    end
  endtask

  task automatic test_random();
    int r;
    drive(1'b0, 5'b00000, 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(99);
      if (r < 55)      drive(1'b1, seq[m_exp[0]], ($urandom_range(19) == 0), ($urandom_range(99) == 0));
      else if (r < 70) drive(1'b1, seq[$urandom_range(15)], 1'b0, 1'b0);
      else if (r < 82) drive(1'b1, bad_codes[$urandom_range(15)], 1'b0, 1'b0);
      else             drive(1'b0, 5'($urandom), ($urandom_range(9) == 0), 1'b0);
      checks++;
      if ({obs_a, obs_b} !== {model_pack(0), model_pack(1)}) begin
        errors++;
        $display("[TB] FAIL rand_model%0d: got %h want %h", n, {obs_a, obs_b}, {model_pack(0), model_pack(1)});
      end
    end
  endtask

  // Run each scenario in turn, then report totals.
  initial begin
    rst = 1'b1; vld = 1'b0; clr = 1'b0; din = 5'b00000;
    test_reset();
    test_clean_acquisition();
    test_invalid_gaps();
    test_flywheel();
    test_loss_of_lock();
    test_saturation();
    test_reset_mid_lock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
